// File: rtl/booth_seq_mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state encoding and the bit positions of the {neg, x2, x1} digit select.
package booth_seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SEL_NEG = 2;
  localparam int SEL_X2  = 1;
  localparam int SEL_X1  = 0;

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth encoder: 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a one-hot-magnitude select {neg, x2, x1}.
module booth_enc
  import booth_seq_mul_pkg::*;
(
  input  logic [2:0] window,
  output logic [2:0] sel
);

  always_comb begin
    sel = '0;
    case (window)
      3'b001, 3'b010: sel[SEL_X1] = 1'b1;
      3'b011:         sel[SEL_X2] = 1'b1;
      3'b100: begin
        sel[SEL_NEG] = 1'b1;
        sel[SEL_X2]  = 1'b1;
      end
      3'b101, 3'b110: begin
        sel[SEL_NEG] = 1'b1;
        sel[SEL_X1]  = 1'b1;
      end
      // All-ones window is a negated zero digit.
      3'b111:         sel[SEL_NEG] = 1'b1;
      default:        sel = '0;
    endcase
  end

endmodule

// File: rtl/booth_pp_sel.sv
// Combinational partial-product select: turns a Booth select and the
// multiplicand into a sign-extended W+2-bit partial product.
module booth_pp_sel
  import booth_seq_mul_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   sel,
  input  logic [W-1:0] a,
  output logic [W+1:0] pp
);

  logic [W+1:0] a_ext;
  logic [W+1:0] mag;

  assign a_ext = {{2{a[W-1]}}, a};

  always_comb begin
    mag = '0;
    if (sel[SEL_X1])      mag = a_ext;
    else if (sel[SEL_X2]) mag = a_ext << 1;
    // Two guard bits keep -(2 * -2^(W-1)) representable.
    pp = sel[SEL_NEG] ? -mag : mag;
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential signed multiplier: one radix-4 Booth digit per clock, W/2 digits,
// then a one-cycle DONE with the product held until the next accepted start.
module booth_seq_mul
  import booth_seq_mul_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output state_t         state
);

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); done is a
  // one-cycle pulse and product stays valid from done until the next start.

  localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

  logic [W-1:0]   a_q;
  logic [W:0]     b_q;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] pp_ext;
  logic [2*W-1:0] acc_next;
  logic [2:0]     sel;
  logic [W+1:0]   pp;

  // b_q carries an implicit b[-1]=0 in bit 0 and shifts two bits per digit.
  booth_enc u_enc (
    .window (b_q[2:0]),
    .sel    (sel)
  );

  booth_pp_sel #(.W(W)) u_pp_sel (
    .sel (sel),
    .a   (a_q),
    .pp  (pp)
  );

  assign pp_ext   = {{(W-2){pp[W+1]}}, pp} << {cnt, 1'b0};
  assign acc_next = acc + pp_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          b_q <= {2'b00, b_q[W:2]};
          if (cnt == LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_next;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul (W=16): directed vectors feed an expected queue,
// a negedge monitor pops and compares on every done pulse.
module tb_booth_seq_mul;
  import booth_seq_mul_pkg::*;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  state_t         state;

  logic [2*W-1:0] exp_q[$];
  int tests;
  int fails;

  booth_seq_mul #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .state   (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got product 0x%08h with no expected entry", product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  // Driver tasks; callers are aligned to a negedge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] ev, input bit push);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) exp_q.push_back(ev);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, lat);
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bcnt, exp_busy);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [2*W-1:0] ev);
    @(negedge clk);
    start_op(av, bv, ev, 1'b1);
    wait_done(name, 9, 8);
  endtask

  logic [W-1:0]   ta[12];
  logic [W-1:0]   tb_v[12];
  logic [2*W-1:0] te[12];

  initial begin
    ta   = '{16'd3,    16'h8000, 16'h7FFF, 16'hFFFF, 16'd1,    16'd3,
             16'd1,    16'hFFFF, 16'd0,    16'h8000, 16'h7FFF, 16'd7};
    tb_v = '{16'd5,    16'h8000, 16'h8000, 16'd1,    16'h5555, 16'h5555,
             16'hAAAA, 16'hAAAA, 16'h1234, 16'h7FFF, 16'h7FFF, 16'd9};
    te   = '{32'h0000000F, 32'h40000000, 32'hC0008000, 32'hFFFFFFFF,
             32'h00005555, 32'h0000FFFF, 32'hFFFFAAAA, 32'h00005556,
             32'h00000000, 32'hC0008000, 32'h3FFF0001, 32'h0000003F};

    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", product, 32'd0);
    check("reset_state", {30'd0, state}, {30'd0, IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) run_op("directed", ta[i], tb_v[i], te[i]);

    // Start during RUN is ignored; operand changes after acceptance are ignored.
    @(negedge clk);
    start_op(16'd7, 16'd9, 32'h0000003F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a     = 16'd2;
    b     = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 16'h1234;
    b     = 16'h4321;
    wait_done("ignored_start", 6, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("product_hold", product, 32'h0000003F);
      check("done_single_pulse", {31'd0, done}, 32'd0);
    end

    // Asynchronous reset mid-RUN, then start on the first edge after release.
    @(negedge clk);
    start_op(16'd123, 16'd45, '0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    check("midrun_reset_product", product, 32'd0);
    check("midrun_reset_state", {30'd0, state}, {30'd0, IDLE});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_op(16'hFFFC, 16'd6, 32'hFFFFFFE8, 1'b1);
    wait_done("after_reset", 9, 8);

    // Back-to-back: new start presented in the DONE cycle.
    @(negedge clk);
    start_op(16'd3, 16'd5, 32'h0000000F, 1'b1);
    wait_done("b2b_first", 9, 8);
    start_op(16'd100, 16'hFF9C, 32'hFFFFD8F0, 1'b1);
    wait_done("b2b_second", 9, 8);

    // Random signed operands against a reference multiply.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      logic [2*W-1:0] rp;
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      rp = 32'($signed(ra) * $signed(rb));
      run_op("random", ra, rb, rp);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
